// File: rtl/alu_multicycle.sv
// Execution stage behind alu_decoder: single-cycle arithmetic/logic/compare,
// serial 1-bit-per-cycle shifter under a start/busy/done handshake.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shop_t;

    state_t           state_q, state_d;
    shop_t            op_q, op_d, dec_op;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             ill_q, ill_d;

    logic [WIDTH-1:0] alu_res;
    logic             is_shift;
    logic             legal;
    logic [SHW-1:0]   shamt;
    logic             fin;
    logic             fin_ill;
    logic [WIDTH-1:0] fin_val;

    function automatic logic [WIDTH-1:0] shift1(
        input shop_t            op,
        input logic [WIDTH-1:0] v
    );
        case (op)
            SH_LL:   shift1 = {v[WIDTH-2:0], 1'b0};
            SH_RL:   shift1 = {1'b0, v[WIDTH-1:1]};
            default: shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction

    assign shamt = SrcB[SHW-1:0];

    // Shift codes yield SrcA here so shamt==0 completes in one cycle.
    always_comb begin
        alu_res  = '0;
        is_shift = 1'b0;
        legal    = 1'b1;
        dec_op   = SH_LL;
        unique case (ALUControl)
            4'b0000: alu_res = SrcA + SrcB;
            4'b0001: alu_res = SrcA - SrcB;
            4'b0010: alu_res = SrcA & SrcB;
            4'b0011: alu_res = SrcA | SrcB;
            4'b0110: alu_res = SrcA ^ SrcB;
            4'b0101: alu_res = {{(WIDTH-1){1'b0}},
                                $signed(SrcA) < $signed(SrcB)};
            4'b1101: alu_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
            4'b0100: begin
                is_shift = 1'b1;
                dec_op   = SH_LL;
                alu_res  = SrcA;
            end
            4'b0111: begin
                is_shift = 1'b1;
                dec_op   = SH_RL;
                alu_res  = SrcA;
            end
            4'b1111: begin
                is_shift = 1'b1;
                dec_op   = SH_RA;
                alu_res  = SrcA;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        ill_d   = ill_q;
        fin     = 1'b0;
        fin_ill = 1'b0;
        fin_val = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_shift && shamt != '0) begin
                        acc_d = shift1(dec_op, SrcA);
                        cnt_d = shamt - SHW'(1);
                        op_d  = dec_op;
                        if (shamt == SHW'(1)) begin
                            fin     = 1'b1;
                            fin_val = acc_d;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        fin     = 1'b1;
                        fin_val = alu_res;
                        fin_ill = ~legal;
                    end
                end
            end
            SHIFT: begin
                acc_d = shift1(op_q, acc_q);
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    fin     = 1'b1;
                    fin_val = acc_d;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fin) begin
            res_d  = fin_val;
            zero_d = (fin_val == '0);
            done_d = 1'b1;
            ill_d  = fin_ill;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= SH_LL;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            ill_q   <= ill_d;
        end
    end

    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign busy      = (state_q == SHIFT);
    assign done      = done_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle against a plain-arithmetic
// reference model, with directed edge cases and random ops.
module tb_alu_multicycle;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        busy;
    logic        done;
    logic        illegal;

    int n_chk  = 0;
    int n_fail = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(
        input  logic [3:0]  c,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] r,
        output logic        il,
        output int          lat
    );
        int n;
        n   = int'(b[4:0]);
        il  = 1'b0;
        lat = 1;
        case (c)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd6:  r = a ^ b;
            4'd5:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd13: r = (a < b) ? 32'd1 : 32'd0;
            4'd4:  r = a << n;
            4'd7:  r = a >> n;
            4'd15: r = $signed(a) >>> n;
            default: begin
                r  = 32'd0;
                il = 1'b1;
            end
        endcase
        if ((c == 4'd4 || c == 4'd7 || c == 4'd15) && n >= 2) lat = n;
    endfunction

    // Issues one op, scrambles inputs afterwards and waits for done.
    task automatic run(
        input  logic [3:0]  c,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] r,
        output logic        z,
        output logic        il,
        output int          edges,
        output bit          bsy,
        output bit          chg,
        output bit          bad
    );
        logic [31:0] old_r;
        logic        old_il;
        old_r  = ALUResult;
        old_il = illegal;
        @(negedge clk);
        ALUControl = c;
        SrcA       = a;
        SrcB       = b;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        ALUControl = 4'($urandom);
        SrcA       = $urandom;
        SrcB       = $urandom;
        edges = 1;
        bsy   = 1'b0;
        chg   = 1'b0;
        while (done !== 1'b1 && edges < 100) begin
            if (busy === 1'b1) bsy = 1'b1;
            if (ALUResult !== old_r || illegal !== old_il) chg = 1'b1;
            @(posedge clk);
            #1;
            edges++;
        end
        bad = (done !== 1'b1) || (busy !== 1'b0);
        r   = ALUResult;
        z   = Zero;
        il  = illegal;
    endtask

    task automatic test_reset;
        reset_n    = 1'b1;
        start      = 1'b0;
        ALUControl = 4'd0;
        SrcA       = 32'd0;
        SrcB       = 32'd0;
        #1 reset_n = 1'b0;
        #2;
        n_chk++;
        if ({ALUResult, Zero, busy, done, illegal} !== {32'd0, 4'b1000}) begin
            n_fail++;
            $display("FAIL reset_state: got res=%h z=%b b=%b d=%b il=%b required 0/1/0/0/0",
                     ALUResult, Zero, busy, done, illegal);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({ALUResult, Zero, busy, done, illegal} !== {32'd0, 4'b1000}) begin
            n_fail++;
            $display("FAIL reset_release: got res=%h z=%b b=%b d=%b il=%b required 0/1/0/0/0",
                     ALUResult, Zero, busy, done, illegal);
        end
    endtask

    task automatic test_ops(
        input string       nm,
        input logic [3:0]  c,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0] r, er;
        logic        z, il, eil;
        int          ed, elat;
        bit          bsy, chg, bad;
        run(c, a, b, r, z, il, ed, bsy, chg, bad);
        model(c, a, b, er, eil, elat);
        n_chk++;
        if (r !== er) begin
            n_fail++;
            $display("FAIL %s result: got %h required %h", nm, r, er);
        end
        n_chk++;
        if (z !== (er == 32'd0) || il !== eil) begin
            n_fail++;
            $display("FAIL %s flags: got z=%b il=%b required z=%b il=%b",
                     nm, z, il, (er == 32'd0), eil);
        end
        n_chk++;
        if (ed != elat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", nm, ed, elat);
        end
        n_chk++;
        if (bad || chg || bsy != (elat > 1)) begin
            n_fail++;
            $display("FAIL %s handshake: got bad=%b chg=%b busy_seen=%b required 0/0/%b",
                     nm, bad, chg, bsy, (elat > 1));
        end
    endtask

    task automatic test_arith;
        test_ops("add_5_7",   4'd0, 32'd5,        32'd7);
        test_ops("sub_7_7",   4'd1, 32'd7,        32'd7);
        test_ops("add_wrap",  4'd0, 32'hFFFFFFFF, 32'd1);
        test_ops("sub_under", 4'd1, 32'd0,        32'd1);
    endtask

    task automatic test_logic_cmp;
        test_ops("slt_neg",  4'd5,  32'hFFFFFFFF, 32'd1);
        test_ops("sltu_neg", 4'd13, 32'hFFFFFFFF, 32'd1);
        test_ops("and",      4'd2,  32'h0000F0F0, 32'h00000FF0);
        test_ops("or",       4'd3,  32'h0000F0F0, 32'h00000FF0);
        test_ops("xor",      4'd6,  32'h0000F0F0, 32'h00000FF0);
    endtask

    task automatic test_shift;
        test_ops("sra_4",   4'd15, 32'h80000000, 32'd4);
        test_ops("srl_4",   4'd7,  32'h80000000, 32'd4);
        test_ops("sll_31",  4'd4,  32'd1,        32'd31);
        test_ops("sll_hib", 4'd4,  32'd1,        32'hFFFFFFE2);
    endtask

    task automatic test_shift_edge;
        test_ops("sll_0", 4'd4,  32'h00001234, 32'd0);
        test_ops("sll_1", 4'd4,  32'h00001234, 32'd1);
        test_ops("sra_1", 4'd15, 32'h80000001, 32'd1);
        test_ops("srl_2", 4'd7,  32'h80000001, 32'd2);
    endtask

    task automatic test_busy_ignore;
        int ed;
        int extra;
        @(negedge clk);
        ALUControl = 4'd15;
        SrcA       = 32'h80000000;
        SrcB       = 32'd8;
        start      = 1'b1;
        @(posedge clk);
        #1;
        ed = 1;
        while (done !== 1'b1 && ed < 100) begin
            @(negedge clk);
            if (ed < 5) begin
                start      = 1'b1;
                ALUControl = 4'd0;
                SrcA       = 32'd5;
                SrcB       = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            ed++;
        end
        start = 1'b0;
        n_chk++;
        if (ALUResult !== 32'hFF800000 || ed != 8) begin
            n_fail++;
            $display("FAIL busy_ignore: got res=%h edges=%0d required FF800000/8",
                     ALUResult, ed);
        end
        extra = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        n_chk++;
        if (extra != 0 || ALUResult !== 32'hFF800000) begin
            n_fail++;
            $display("FAIL busy_no_queue: got extra_done=%0d res=%h required 0/FF800000",
                     extra, ALUResult);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        logic        z, il, d_now;
        int          ed;
        bit          bsy, chg, bad;
        run(4'd0, 32'd5, 32'd7, r, z, il, ed, bsy, chg, bad);
        d_now = done;
        run(4'd1, 32'd9, 32'd2, r, z, il, ed, bsy, chg, bad);
        n_chk++;
        if (d_now !== 1'b1 || r !== 32'd7 || ed != 1 || bad) begin
            n_fail++;
            $display("FAIL b2b_alu: got prev_done=%b res=%h edges=%0d bad=%b required 1/7/1/0",
                     d_now, r, ed, bad);
        end
        d_now = done;
        run(4'd4, 32'd3, 32'd5, r, z, il, ed, bsy, chg, bad);
        n_chk++;
        if (d_now !== 1'b1 || r !== 32'd96 || ed != 5 || bad) begin
            n_fail++;
            $display("FAIL b2b_shift: got prev_done=%b res=%h edges=%0d bad=%b required 1/60/5/0",
                     d_now, r, ed, bad);
        end
    endtask

    task automatic test_reset_midshift;
        logic [31:0] r;
        logic        z, il;
        int          ed, pulses;
        bit          bsy, chg, bad;
        run(4'd0, 32'd3, 32'd4, r, z, il, ed, bsy, chg, bad);
        n_chk++;
        if (r !== 32'd7) begin
            n_fail++;
            $display("FAIL pre_reset_add: got %h required 00000007", r);
        end
        @(negedge clk);
        ALUControl = 4'd4;
        SrcA       = 32'd1;
        SrcB       = 32'd20;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_chk++;
        if ({ALUResult, Zero, busy, done, illegal} !== {32'd0, 4'b1000}) begin
            n_fail++;
            $display("FAIL reset_midshift: got res=%h z=%b b=%b d=%b il=%b required 0/1/0/0/0",
                     ALUResult, Zero, busy, done, illegal);
        end
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) pulses++;
        end
        n_chk++;
        if (pulses != 0 || ALUResult !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_no_done: got stray=%0d res=%h required 0/0", pulses, ALUResult);
        end
    endtask

    task automatic test_illegal;
        test_ops("add_pre",   4'd0,  32'd20,   32'd22);
        test_ops("ill_1000",  4'd8,  32'd5,    32'd6);
        test_ops("add_clear", 4'd0,  32'd1,    32'd1);
        test_ops("ill_1110",  4'd14, 32'd9,    32'd9);
        test_ops("sra_clear", 4'd15, 32'hF000, 32'd6);
    endtask

    task automatic test_random;
        logic [3:0] codes [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6,
                                   4'd5, 4'd13, 4'd4, 4'd7, 4'd15};
        logic [3:0] c;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) c = 4'($urandom);
            else c = codes[$urandom_range(0, 9)];
            test_ops("random", c, $urandom, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic_cmp();
        test_shift();
        test_shift_edge();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midshift();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
